// File: rtl/bcd_to_time.sv
// Binary seconds count to registered BCD MM:SS word, saturating at 59:59.
// Constant divisions use reciprocal multiplies with a remainder correction.
module bcd_to_time (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] count,
  output logic [15:0] time_out
);

  logic [15:0] time_q, time_d;

  logic [11:0] sat_c;
  logic [22:0] prod60;
  logic [6:0]  min_est;
  logic [11:0] rem_est;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;

  // x / 10 for x in 0..59: 13/128 overestimates by < 0.1, never crossing a digit
  function automatic logic [7:0] div10(input logic [5:0] x);
    logic [10:0] p;
    logic [3:0]  q;
    logic [5:0]  r;
    p = {5'd0, x} * 11'd13;
    q = 4'(p >> 7);
    r = x - 6'({2'd0, q} * 6'd10);
    return {q, 4'(r)};
  endfunction

  always_comb begin
    sat_c   = (count > 12'd3599) ? 12'd3599 : count;
    // 1092/65536 underestimates 1/60, so the quotient is at most one low
    prod60  = {11'd0, sat_c} * 23'd1092;
    min_est = 7'(prod60 >> 16);
    rem_est = sat_c - ({5'd0, min_est} * 12'd60);
    minutes = 6'(min_est);
    seconds = 6'(rem_est);
    if (rem_est >= 12'd60) begin
      minutes = 6'(min_est + 7'd1);
      seconds = 6'(rem_est - 12'd60);
    end
    {min_tens, min_ones} = div10(minutes);
    {sec_tens, sec_ones} = div10(seconds);
    time_d = {min_tens, min_ones, sec_tens, sec_ones};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) time_q <= 16'h0000;
    else        time_q <= time_d;
  end

  assign time_out = time_q;

endmodule

// File: tb/tb_bcd_to_time.sv
// Directed and exhaustive checks of bcd_to_time against hand values and a
// divide/modulo reference.
module tb_bcd_to_time;

  logic        clk;
  logic        rst_n;
  logic [11:0] count;
  logic [15:0] time_out;

  int passed = 0;
  int total  = 0;

  bcd_to_time dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (count),
    .time_out (time_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic apply(input logic [11:0] c, input logic [15:0] exp, input string tag);
    @(negedge clk);
    count = c;
    @(posedge clk);
    #1;
    chk(tag, time_out, exp);
  endtask

  function automatic logic [15:0] model(input int c);
    int cs, m, s;
    cs = (c > 3599) ? 3599 : c;
    m  = cs / 60;
    s  = cs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic legal(input logic [15:0] v);
    return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
           (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  initial begin
    rst_n = 1'b0;
    count = 12'd345;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", time_out, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_between_edges", time_out, 16'h0000);
    @(posedge clk);
    #1;
    chk("first_edge_after_reset", time_out, 16'h0545);

    apply(12'd0,    16'h0000, "vec_0");
    apply(12'd90,   16'h0130, "vec_90");
    apply(12'd345,  16'h0545, "vec_345");
    apply(12'd3599, 16'h5959, "vec_3599");
    apply(12'd1397, 16'h2317, "vec_1397");

    apply(12'd59,  16'h0059, "roll_59");
    apply(12'd60,  16'h0100, "roll_60");
    apply(12'd599, 16'h0959, "roll_599");
    apply(12'd600, 16'h1000, "roll_600");

    apply(12'd3600, 16'h5959, "sat_3600");
    apply(12'd4000, 16'h5959, "sat_4000");
    apply(12'd4095, 16'h5959, "sat_4095");

    // input changes between edges must not reach the output early
    apply(12'd1397, 16'h2317, "hold_pre");
    @(negedge clk);
    count = 12'd59;
    #1;
    chk("no_early_update", time_out, 16'h2317);
    @(posedge clk);
    #1;
    chk("late_update", time_out, 16'h0059);

    for (int c = 0; c < 4096; c++) begin
      @(negedge clk);
      count = 12'(c);
      @(posedge clk);
      #1;
      chk($sformatf("sweep_%0d", c), time_out, model(c));
      chk($sformatf("legal_%0d", c), {15'd0, legal(time_out)}, 16'h0001);
    end

    apply(12'd1397, 16'h2317, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", time_out, 16'h0000);
    count = 12'd600;
    repeat (2) @(posedge clk);
    #1;
    chk("async_hold_low", time_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_async_release", time_out, 16'h1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
